rr_encoder_5_bit: RTL and testbench

- Round-robin priority encoder: the inverse of the 5-bit one-hot decoder.
- Collects 32 level-sensitive request lines, one per ROMix core, and picks one fairly.
- Presents the winner as a registered 5-bit binary index with a valid/ready handshake.
- On acceptance, returns a one-cycle one-hot acknowledge to the winning core.
- Sits between the ROMix core array and the shared result/scratchpad-access path.

---
 rtl/rr_encoder_5_bit.sv | 108 ++++++++++
 tb/tb_rr_encoder_5_bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_5_bit.sv
// Round-robin priority encoder: picks one of 2**IDX_W level requests fairly,
// presents its index with a valid/ready handshake and pulses a one-hot ack.
module rr_encoder_5_bit #(
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2**IDX_W-1:0]   req,
  output logic [IDX_W-1:0]      idx,
  output logic                  idx_valid,
  input  logic                  idx_ready,
  output logic [2**IDX_W-1:0]   ack,
  output logic [IDX_W:0]        req_cnt
);

  localparam int N = 2**IDX_W;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [IDX_W:0]   cnt_q, cnt_d;

  logic [N-1:0]     mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] hi_idx, lo_idx, winner;

  // Bits at or above the pointer get first pick; below-pointer bits are the wrap-around.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (IDX_W'(gi) >= ptr_q);
    end
  endgenerate

  always_comb begin
    masked = req & mask;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) hi_idx = IDX_W'(i);
      if (req[i])    lo_idx = IDX_W'(i);
    end
    winner = (|masked) ? hi_idx : lo_idx;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + (IDX_W+1)'(req[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          idx_d   = winner;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // req is deliberately ignored here: the selection stands until accepted.
        if (idx_ready) begin
          ack_d[idx_q] = 1'b1;
          valid_d      = 1'b0;
          ptr_d        = idx_q + IDX_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = valid_q;
  assign ack       = ack_q;
  assign req_cnt   = cnt_q;

endmodule

// File: tb/tb_rr_encoder_5_bit.sv
// Bench for rr_encoder_5_bit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_rr_encoder_5_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] req;
  logic [4:0]  idx;
  logic        idx_valid;
  logic        idx_ready;
  logic [31:0] ack;
  logic [5:0]  req_cnt;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Reference model state
  logic        m_valid = 1'b0;
  int          m_idx   = 0;
  int          m_ptr   = 0;
  logic [31:0] m_ack   = '0;
  int          m_cnt   = 0;

  rr_encoder_5_bit #(.IDX_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .ack       (ack),
    .req_cnt   (req_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++) begin
      if (r[(p + k) % 32]) return (p + k) % 32;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a granted index is held until accepted; acceptance moves the pointer past it.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_ack   <= '0;
      m_cnt   <= 0;
    end else begin
      m_cnt <= $countones(req);
      m_ack <= '0;
      if (m_valid) begin
        if (idx_ready) begin
          m_ack   <= 32'd1 << m_idx;
          m_valid <= 1'b0;
          m_ptr   <= (m_idx + 1) % 32;
        end
      end else if (en && req != 0) begin
        m_idx   <= pick(req, m_ptr);
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_idx_valid", {31'd0, idx_valid}, {31'd0, m_valid});
      chk("model_idx", {27'd0, idx}, 32'(m_idx));
      chk("model_ack", ack, m_ack);
      chk("model_req_cnt", {26'd0, req_cnt}, 32'(m_cnt));
    end
  end

  initial begin
    int exp_seq[4];
    exp_seq = '{0, 31, 0, 31};
    rst = 1'b1; en = 1'b0; req = 32'hFFFF_FFFF; idx_ready = 1'b0;
    step();
    started = 1'b1;
    repeat (2) step();

    // Reset and count
    rst = 1'b0;
    chk("rst_valid", {31'd0, idx_valid}, 32'd0);
    chk("rst_ack", ack, 32'd0);
    chk("rst_idx", {27'd0, idx}, 32'd0);
    step();
    chk("cnt_all", {26'd0, req_cnt}, 32'd32);
    req = 32'h0;
    step();

    // Single request, then prove ptr moved to 11
    en = 1'b1; req = 32'h0000_0400; idx_ready = 1'b1;
    step();
    chk("single_valid", {31'd0, idx_valid}, 32'd1);
    chk("single_idx", {27'd0, idx}, 32'd10);
    step();
    chk("single_ack", ack, 32'h0000_0400);
    req = 32'h0000_0C00;
    step();
    chk("ptr11_idx", {27'd0, idx}, 32'd11);
    req = 32'h0;
    step();
    chk("ptr11_ack", ack, 32'h0000_0800);

    // Round-robin fairness from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0; req = 32'h8000_0001;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr_idx", {27'd0, idx}, 32'(exp_seq[g]));
      chk("rr_valid", {31'd0, idx_valid}, 32'd1);
      step();
      chk("rr_ack", ack, 32'd1 << exp_seq[g]);
    end

    // Backpressure: ptr is 0 after granting 31
    idx_ready = 1'b0; req = 32'h0000_0030;
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = 32'h0;
      step();
      chk("bp_idx", {27'd0, idx}, 32'd4);
      chk("bp_valid", {31'd0, idx_valid}, 32'd1);
    end
    idx_ready = 1'b1;
    step();
    chk("bp_ack", ack, 32'h0000_0010);
    idx_ready = 1'b0;

    // Enable gating
    en = 1'b0; req = 32'h00FF_0000;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("en_gate_valid", {31'd0, idx_valid}, 32'd0);
    end
    en = 1'b1;
    step();
    chk("en_idx", {27'd0, idx}, 32'd16);
    idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;

    // Reset mid-HOLD: ptr is 17, so idx 7 is reached by wrapping
    req = 32'h0000_0080;
    step();
    chk("mid_idx", {27'd0, idx}, 32'd7);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, idx_valid}, 32'd0);
    chk("mid_rst_ack", ack, 32'd0);
    rst = 1'b0; req = 32'h0000_0081;
    step();
    chk("post_rst_idx", {27'd0, idx}, 32'd0);
    idx_ready = 1'b1;
    step();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 4))
        0: req = 32'h0;
        1: req = 32'd1 << $urandom_range(0, 31);
        2: req = 32'hFFFF_FFFF;
        3: req = $urandom & $urandom;
        default: req = $urandom;
      endcase
      en        = ($urandom_range(0, 9) < 7);
      idx_ready = ($urandom_range(0, 9) < 5);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
